light_sequencer: RTL and testbench
==================================

LIGHT_SEQUENCER -- requirements
Module: light_sequencer

Interface
REQ-001 SHALL have parameter GREEN_TICKS, default 8, meaning green phase length in clock cycles (minimum 1).
REQ-002 SHALL have parameter YELLOW_TICKS, default 3, meaning yellow phase length in cycles (minimum 1).
REQ-003 SHALL have parameter ALLRED_TICKS, default 2, meaning all-red clearance length in cycles (minimum 1).
REQ-004 SHALL have parameter MAX_WAIT, default 20, meaning wait-cycle threshold that marks a lane starved (1..255).
REQ-005 SHALL have the port Clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have the port Reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have the port Lanes, input, 4 bits: raw lane-occupied sensors, one bit per lane.
REQ-008 SHALL have the port Priority, input, 4 bits: the compatible lane-grant set produced by the priority encoder.
REQ-009 SHALL have the port Green, output, 4 bits: the per-lane green lamps.
REQ-010 SHALL have the port Yellow, output, 4 bits: the per-lane yellow lamps.
REQ-011 SHALL have the port Red, output, 4 bits: the per-lane red lamps.
REQ-012 SHALL have the port Served, output, 4 bits: a one-cycle pulse marking lanes whose green phase just ended.
REQ-013 SHALL have the port Busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, GREEN, YELLOW and ALLRED, with every output registered.
REQ-015 SHALL make IDLE a no-change state while the selected grant is 0000, with all lamps red.
REQ-016 SHALL, in IDLE with a nonzero selected grant at edge N, latch the grant into Active, enter GREEN and show Green=Active from cycle N+1.
REQ-017 SHALL use a selected grant equal to the lowest-index starved lane alone if any starved lane exists, and equal to Priority otherwise.
REQ-018 SHALL define a lane as starved when its wait counter is at least MAX_WAIT.
REQ-019 SHALL hold GREEN for exactly GREEN_TICKS cycles, then YELLOW for exactly YELLOW_TICKS cycles, then ALLRED for exactly ALLRED_TICKS cycles, then return to IDLE.
REQ-020 SHALL drive Yellow=Active in YELLOW and all lamps red in ALLRED.
REQ-021 SHALL pulse Served=Active for exactly one cycle, in the first YELLOW cycle.
REQ-022 SHALL drive Red=~(Green|Yellow) in every cycle, so exactly one lamp per lane is lit.
REQ-023 SHALL ignore changes on Priority and Lanes for lamp selection while not in IDLE.
REQ-024 SHALL keep an 8-bit wait counter per lane that increments each cycle Lanes[i]=1 and Green[i]=0.
REQ-025 SHALL make each wait counter saturate at 255.
REQ-026 SHALL clear a lane's wait counter when Green[i]=1 or Lanes[i]=0.
REQ-027 SHALL resolve a simultaneous increment and clear of a wait counter in favour of the clear.
REQ-028 SHALL use a single down-counter wide enough for max(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS), reloaded on each state entry.
REQ-029 SHALL never assert Green on a lane that is not in Active.

Reset
REQ-030 SHALL, when Reset=1 at a clock edge, force state IDLE, Active=0000, Green=0000, Yellow=0000, Red=1111, Served=0000, Busy=0, all wait counters to 0 and the phase counter to 0.
REQ-031 SHALL apply reset asserted mid-phase (any state) on the next edge, with no yellow or clearance interval.
REQ-032 SHALL evaluate the first grant no earlier than the first edge after Reset deasserts.

Structure
REQ-033 SHALL place the FSM state encoding and the default tick and MAX_WAIT constants in a shared traffic package.
REQ-034 SHALL use one sub-module, lane_wait_counter, instantiated four times, holding the saturating counter and the starved flag.
REQ-035 SHALL implement the FSM, phase counter and starvation override selection in light_sequencer itself.

Verification
REQ-036 SHALL cover the basic cycle: Priority=0101 held from reset release -> Green=0101 for 8 cycles, Yellow=0101 for 3, all-red for 2, Served=0101 pulsed once, then regrant.
REQ-037 SHALL cover idle: Priority=0000 for 50 cycles -> Red=1111, Busy=0 and no Served pulse.
REQ-038 SHALL cover starvation: Lanes=1111 with Priority fixed at 1100 -> lane 0 reaches 20 waits, so the next IDLE grants Green=0001 alone, and lane 0's counter returns to 0.
REQ-039 SHALL cover mid-phase reset: Reset=1 on the 4th GREEN cycle -> next cycle Red=1111, Busy=0, Served=0000 and no yellow.
REQ-040 SHALL cover input stability: Priority toggled 0011->1000 during GREEN -> Green stays 0011 through the phase, and 1000 is granted only after ALLRED.
REQ-041 SHALL cover saturation: Lanes[3]=1 with lane 3 never granted for 300 cycles and MAX_WAIT=255 -> the counter holds at 255 without wrapping.

Source files
------------

// File: rtl/light_sequencer_pkg.sv
// Shared types and defaults for the four-lane light sequencer.
// Holds the FSM encoding, phase/wait defaults and small helper functions.
package light_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2,
    ST_ALLRED = 2'd3
  } state_e;

  localparam int NUM_LANES        = 4;
  localparam int WAIT_W           = 8;
  localparam int DEF_GREEN_TICKS  = 8;
  localparam int DEF_YELLOW_TICKS = 3;
  localparam int DEF_ALLRED_TICKS = 2;
  localparam int DEF_MAX_WAIT     = 20;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Isolates the least-significant set bit (two's-complement trick).
  function automatic logic [NUM_LANES-1:0] lowest_one(input logic [NUM_LANES-1:0] v);
    return v & (~v + {{(NUM_LANES-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/light_sequencer_wait.sv
// Per-lane saturating wait counter with a starved flag.
// Counts cycles a lane is occupied but not green; clear wins over increment.
module lane_wait_counter
  import light_sequencer_pkg::*;
#(
  parameter int MAX_WAIT = DEF_MAX_WAIT
) (
  input  logic clk,
  input  logic rst,
  input  logic lane,
  input  logic green,
  output logic starved
);

  localparam logic [WAIT_W-1:0] SAT = '1;
  localparam logic [WAIT_W-1:0] ONE = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] THR = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!lane || green)    cnt_d = '0;
    else if (cnt_q != SAT) cnt_d = cnt_q + ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign starved = (cnt_q >= THR);

endmodule

// File: rtl/light_sequencer.sv
// Four-lane traffic light sequencer: IDLE -> GREEN -> YELLOW -> ALLRED -> IDLE,
// with a starvation override that grants the lowest starved lane alone.
module light_sequencer
  import light_sequencer_pkg::*;
#(
  parameter int GREEN_TICKS  = DEF_GREEN_TICKS,
  parameter int YELLOW_TICKS = DEF_YELLOW_TICKS,
  parameter int ALLRED_TICKS = DEF_ALLRED_TICKS,
  parameter int MAX_WAIT     = DEF_MAX_WAIT
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic [NUM_LANES-1:0] Lanes,
  input  logic [NUM_LANES-1:0] Priority,
  output logic [NUM_LANES-1:0] Green,
  output logic [NUM_LANES-1:0] Yellow,
  output logic [NUM_LANES-1:0] Red,
  output logic [NUM_LANES-1:0] Served,
  output logic                 Busy
);

  localparam int MAX_TICKS = max3(GREEN_TICKS, YELLOW_TICKS, ALLRED_TICKS);
  localparam int CNT_W     = $clog2(MAX_TICKS + 1);

  localparam logic [CNT_W-1:0] G_LOAD  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] Y_LOAD  = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] A_LOAD  = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e               state_q, state_d;
  logic [NUM_LANES-1:0] active_q, active_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_LANES-1:0] green_q, green_d;
  logic [NUM_LANES-1:0] yellow_q, yellow_d;
  logic [NUM_LANES-1:0] red_q, red_d;
  logic [NUM_LANES-1:0] served_q, served_d;
  logic                 busy_q, busy_d;

  logic [NUM_LANES-1:0] starved;
  logic [NUM_LANES-1:0] sel_grant;

  // Wait counters watch the registered lamp, i.e. what drivers actually see.
  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    lane_wait_counter #(.MAX_WAIT(MAX_WAIT)) u_wait (
      .clk     (Clock),
      .rst     (Reset),
      .lane    (Lanes[i]),
      .green   (green_q[i]),
      .starved (starved[i])
    );
  end

  assign sel_grant = (starved != '0) ? lowest_one(starved) : Priority;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    served_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (sel_grant != '0) begin
          state_d  = ST_GREEN;
          active_d = sel_grant;
          cnt_d    = G_LOAD;
        end
      end
      ST_GREEN: begin
        if (cnt_q == '0) begin
          state_d  = ST_YELLOW;
          cnt_d    = Y_LOAD;
          served_d = active_q;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_YELLOW: begin
        if (cnt_q == '0) begin
          state_d = ST_ALLRED;
          cnt_d   = A_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_ALLRED: begin
        if (cnt_q == '0) begin
          state_d  = ST_IDLE;
          cnt_d    = '0;
          active_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        cnt_d    = '0;
        active_d = '0;
      end
    endcase

    // Lamps derive from the next state so they are registered with it.
    green_d  = (state_d == ST_GREEN)  ? active_d : '0;
    yellow_d = (state_d == ST_YELLOW) ? active_d : '0;
    red_d    = ~(green_d | yellow_d);
    busy_d   = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      cnt_q    <= '0;
      green_q  <= '0;
      yellow_q <= '0;
      red_q    <= '1;
      served_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      green_q  <= green_d;
      yellow_q <= yellow_d;
      red_q    <= red_d;
      served_q <= served_d;
      busy_q   <= busy_d;
    end
  end

  assign Green  = green_q;
  assign Yellow = yellow_q;
  assign Red    = red_q;
  assign Served = served_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_light_sequencer.sv
// Randomized and directed checks of light_sequencer against a time-based
// reference model (grant time + elapsed cycles decide every lamp).
module tb_light_sequencer;

  localparam int G = 8;
  localparam int Y = 3;
  localparam int A = 2;

  logic       Clock, Reset;
  logic [3:0] Lanes, Priority;
  logic [3:0] g0, y0, r0, s0, g1, y1, r1, s1;
  logic       b0, b1;

  light_sequencer #(.GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A), .MAX_WAIT(20)) dut (
    .Clock(Clock), .Reset(Reset), .Lanes(Lanes), .Priority(Priority),
    .Green(g0), .Yellow(y0), .Red(r0), .Served(s0), .Busy(b0));

  light_sequencer #(.GREEN_TICKS(G), .YELLOW_TICKS(Y), .ALLRED_TICKS(A), .MAX_WAIT(255)) dut_sat (
    .Clock(Clock), .Reset(Reset), .Lanes(Lanes), .Priority(Priority),
    .Green(g1), .Yellow(y1), .Red(r1), .Served(s1), .Busy(b1));

  always #5 Clock = ~Clock;

  int nvec, nerr, cyc;
  int m_maxw [2];
  logic m_inb [2];
  logic [3:0] m_act [2];
  int m_t0 [2];
  int m_wait [2][4];

  // Expected {Green, Yellow, Red, Served, Busy} for the current cycle.
  function automatic logic [16:0] exp_out(input int m);
    int k;
    logic [3:0] g, y, s;
    g = '0; y = '0; s = '0;
    if (m_inb[m]) begin
      k = cyc - m_t0[m];
      if (k < G) g = m_act[m];
      else if (k < G + Y) y = m_act[m];
      if (k == G) s = m_act[m];
    end
    return {g, y, ~(g | y), s, m_inb[m]};
  endfunction

  task automatic model_step(input int m);
    logic [16:0] o;
    logic [3:0] gpre, sel;
    logic found;
    o = exp_out(m);
    gpre = o[16:13];
    if (Reset) begin
      m_inb[m] = 1'b0;
      m_act[m] = '0;
      for (int i = 0; i < 4; i++) m_wait[m][i] = 0;
    end else begin
      sel = Priority;
      found = 1'b0;
      for (int i = 0; i < 4; i++)
        if (!found && m_wait[m][i] >= m_maxw[m]) begin
          sel = 4'b0001 << i;
          found = 1'b1;
        end
      for (int i = 0; i < 4; i++)
        if (Lanes[i] && !gpre[i]) m_wait[m][i] = (m_wait[m][i] < 255) ? m_wait[m][i] + 1 : 255;
        else m_wait[m][i] = 0;
      if (!m_inb[m]) begin
        if (sel != '0) begin
          m_inb[m] = 1'b1;
          m_act[m] = sel;
          m_t0[m]  = cyc + 1;
        end
      end else if (cyc + 1 - m_t0[m] == G + Y + A) begin
        m_inb[m] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    model_step(0);
    model_step(1);
    cyc++;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Lanes = 4'b1111; Priority = 4'b1111;
    do_reset();
    nvec++;
    if ({g0, y0, r0, s0, b0} !== exp_out(0)) begin
      nerr++; $display("FAIL reset_dut got=%h exp=%h", {g0, y0, r0, s0, b0}, exp_out(0));
    end
    nvec++;
    if ({g1, y1, r1, s1, b1} !== 17'b0000_0000_1111_0000_0) begin
      nerr++; $display("FAIL reset_sat got=%h exp=%h", {g1, y1, r1, s1, b1}, 17'b0000_0000_1111_0000_0);
    end
  endtask

  task automatic test_basic();
    int ng, ny, ns, regrant;
    Lanes = '0; Priority = 4'b0101;
    do_reset();
    ng = 0; ny = 0; ns = 0; regrant = 0;
    for (int c = 0; c < G + Y + A + 2; c++) begin
      tick();
      nvec++;
      if ({g0, y0, r0, s0, b0} !== exp_out(0)) begin
        nerr++; $display("FAIL basic cyc=%0d got=%h exp=%h", cyc, {g0, y0, r0, s0, b0}, exp_out(0));
      end
      if (c < G + Y + A) begin
        if (g0 == 4'b0101) ng++;
        if (y0 == 4'b0101) ny++;
        if (s0 == 4'b0101) ns++;
      end else if (c == G + Y + A + 1 && g0 == 4'b0101) regrant = 1;
    end
    nvec++;
    if ({ng, ny, ns, regrant} !== {G, Y, 32'd1, 32'd1}) begin
      nerr++; $display("FAIL basic_counts got g=%0d y=%0d s=%0d re=%0d exp g=%0d y=%0d s=1 re=1", ng, ny, ns, regrant, G, Y);
    end
  endtask

  task automatic test_idle();
    int bad;
    Lanes = '0; Priority = '0;
    do_reset();
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      nvec++;
      if ({g0, y0, r0, s0, b0} !== exp_out(0)) begin
        nerr++; $display("FAIL idle cyc=%0d got=%h exp=%h", cyc, {g0, y0, r0, s0, b0}, exp_out(0));
      end
      if (r0 !== 4'b1111 || b0 !== 1'b0 || s0 !== 4'b0000) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++; $display("FAIL idle_lamps bad_cycles=%0d exp=0", bad);
    end
  endtask

  task automatic test_starvation();
    int seen, cleared;
    Lanes = 4'b1111; Priority = 4'b1100;
    do_reset();
    seen = 0; cleared = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      nvec++;
      if ({g0, y0, r0, s0, b0} !== exp_out(0)) begin
        nerr++; $display("FAIL starve cyc=%0d got=%h exp=%h", cyc, {g0, y0, r0, s0, b0}, exp_out(0));
      end
      if (g0 == 4'b0001) begin
        seen = 1;
        if (dut.g_lane[0].u_wait.cnt_q == 8'd0) cleared = 1;
      end
    end
    nvec++;
    if (seen != 1 || cleared != 1) begin
      nerr++; $display("FAIL starve_grant seen=%0d cleared=%0d exp 1 1", seen, cleared);
    end
  endtask

  task automatic test_mid_reset();
    int ng, ylw;
    Lanes = '0; Priority = 4'b0011;
    do_reset();
    ng = 0;
    for (int c = 0; c < 20 && ng < 4; c++) begin
      tick();
      if (g0 != '0) ng++;
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0; Priority = '0;
    nvec++;
    if ({r0, b0, s0, y0} !== {4'b1111, 1'b0, 4'b0000, 4'b0000} || {g0, y0, r0, s0, b0} !== exp_out(0)) begin
      nerr++; $display("FAIL mid_reset ng=%0d got=%h exp=%h", ng, {g0, y0, r0, s0, b0}, exp_out(0));
    end
    ylw = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (y0 != '0 || g0 != '0) ylw++;
    end
    nvec++;
    if (ylw != 0) begin
      nerr++; $display("FAIL mid_reset_noyellow lit_cycles=%0d exp=0", ylw);
    end
  endtask

  task automatic test_stability();
    int c1, c8;
    Lanes = '0; Priority = 4'b0011;
    do_reset();
    c1 = -1; c8 = -1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (c == 2) Priority = 4'b1000;
      nvec++;
      if ({g0, y0, r0, s0, b0} !== exp_out(0)) begin
        nerr++; $display("FAIL stable cyc=%0d got=%h exp=%h", cyc, {g0, y0, r0, s0, b0}, exp_out(0));
      end
      if (g0 == 4'b0011 && c1 < 0) c1 = c;
      if (g0 == 4'b1000 && c8 < 0) c8 = c;
    end
    nvec++;
    if (c1 != 0 || c8 != G + Y + A + 1) begin
      nerr++; $display("FAIL stable_timing got first0011=%0d first1000=%0d exp 0 %0d", c1, c8, G + Y + A + 1);
    end
  endtask

  task automatic test_saturation();
    int mx;
    logic [7:0] cnt;
    Lanes = 4'b1000; Priority = 4'b0001;
    do_reset();
    mx = 0;
    for (int c = 0; c < 300; c++) begin
      tick();
      cnt = dut_sat.g_lane[3].u_wait.cnt_q;
      nvec++;
      if (cnt !== 8'(m_wait[1][3]) || {g1, y1, r1, s1, b1} !== exp_out(1)) begin
        nerr++; $display("FAIL saturate cyc=%0d cnt=%0d exp=%0d out=%h exp=%h", cyc, cnt, m_wait[1][3], {g1, y1, r1, s1, b1}, exp_out(1));
      end
      if (int'(cnt) > mx) mx = int'(cnt);
    end
    nvec++;
    if (mx != 255) begin
      nerr++; $display("FAIL saturate_max got=%0d exp=255", mx);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) Lanes = 4'($urandom);
      if ($urandom_range(0, 3) == 0) Priority = 4'($urandom);
      Reset = ($urandom_range(0, 99) == 0);
      tick();
      nvec++;
      if ({g0, y0, r0, s0, b0} !== exp_out(0)) begin
        nerr++; $display("FAIL random cyc=%0d got=%h exp=%h", cyc, {g0, y0, r0, s0, b0}, exp_out(0));
      end
      nvec++;
      if ({g1, y1, r1, s1, b1} !== exp_out(1)) begin
        nerr++; $display("FAIL random_sat cyc=%0d got=%h exp=%h", cyc, {g1, y1, r1, s1, b1}, exp_out(1));
      end
    end
    Reset = 1'b0;
  endtask

  initial begin
    Clock = 1'b0; Reset = 1'b1; Lanes = '0; Priority = '0;
    nvec = 0; nerr = 0; cyc = 0;
    m_maxw[0] = 20; m_maxw[1] = 255;
    for (int m = 0; m < 2; m++) begin
      m_inb[m] = 1'b0; m_act[m] = '0; m_t0[m] = 0;
      for (int i = 0; i < 4; i++) m_wait[m][i] = 0;
    end
    test_reset();
    test_basic();
    test_idle();
    test_starvation();
    test_mid_reset();
    test_stability();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
